// File: rtl/exu_wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exu_wb_arb_pkg : shared types and unit indices for the EXU wb arbiter |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package exu_wb_arb_pkg;

    localparam int XLEN   = 32;

    localparam int WB_ALU = 0;
    localparam int WB_MUL = 1;
    localparam int WB_DIV = 2;
    localparam int WB_LSU = 3;
    localparam int WB_MAC = 4;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] instr_tag;
        logic [31:0]     instr;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/exu_wb_arb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exu_wb_fifo : per-unit holding FIFO for writeback requests            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module exu_wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  wb_req_t                        push_data,
    input  logic                           pop,
    output wb_req_t                        pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/exu_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exu_wb_arb : round-robin writeback arbiter, ALU/MUL/DIV/LSU/MAC->IDU1 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int NREQ  = 5,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  wb_req_t [NREQ-1:0]        req_wb,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           req_pending,
    output logic [XLEN-1:0]           exu_wb_data,
    output logic [4:0]                exu_wb_rd_addr,
    output logic                      exu_wb_rd_wr_en,
    output logic [XLEN-1:0]           instr_tag_out,
    output logic [31:0]               instr_out,
    output logic [31:0]               wb_conflict_cnt
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]   r_rr_ptr;

    logic [NREQ-1:0]    w_full;
    logic [NREQ-1:0]    w_empty;
    logic [CNT_W-1:0]   w_count [NREQ];
    wb_req_t            w_head  [NREQ];
    wb_req_t            w_cand  [NREQ];
    logic [NREQ-1:0]    w_accept;
    logic [NREQ-1:0]    w_cand_valid;
    logic [NREQ-1:0]    w_push;
    logic [NREQ-1:0]    w_pop;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_win;
    logic               w_grant;
    logic               w_conflict;
    wb_req_t            w_win_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
            exu_wb_fifo #(
                .DEPTH     (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[gi]),
                .push_data (req_wb[gi]),
                .pop       (w_pop[gi]),
                .pop_data  (w_head[gi]),
                .full      (w_full[gi]),
                .empty     (w_empty[gi]),
                .count     (w_count[gi])
            );
        end
    endgenerate

    assign req_ready = ~w_full;

    // A unit's incoming request is only a candidate when its FIFO is empty,
    // so per-unit ordering is preserved.
    always_comb begin
        w_accept     = '0;
        w_cand_valid = '0;
        req_pending  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_accept[i]     = req_valid[i] & ~w_full[i];
            w_cand_valid[i] = ~w_empty[i] | w_accept[i];
            w_cand[i]       = w_empty[i] ? req_wb[i] : w_head[i];
            req_pending[i]  = (w_count[i] != '0);
        end
    end

    always_comb begin
        w_grant   = 1'b0;
        w_win     = '0;
        w_idx     = '0;
        w_win_req = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NREQ));
            if (!w_grant && w_cand_valid[w_idx]) begin
                w_grant = 1'b1;
                w_win   = w_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && (w_win == PTR_W'(i))) w_win_req = w_cand[i];
        end
        w_conflict = ($countones(w_cand_valid) > 1);
    end

    // A bypassed winner never enters its FIFO; every other acceptance is stored.
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pop[i]  = w_grant && (w_win == PTR_W'(i)) && !w_empty[i];
            w_push[i] = w_accept[i] && !(w_grant && (w_win == PTR_W'(i)) && w_empty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr        <= '0;
            exu_wb_data     <= '0;
            exu_wb_rd_addr  <= '0;
            exu_wb_rd_wr_en <= 1'b0;
            instr_tag_out   <= '0;
            instr_out       <= '0;
            wb_conflict_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr        <= (w_win == PTR_W'(NREQ-1)) ? '0 : w_win + 1'b1;
                exu_wb_data     <= w_win_req.data;
                exu_wb_rd_addr  <= w_win_req.rd_addr;
                exu_wb_rd_wr_en <= (w_win_req.rd_addr != 5'd0);
                instr_tag_out   <= w_win_req.instr_tag;
                instr_out       <= w_win_req.instr;
            end else begin
                exu_wb_data     <= '0;
                exu_wb_rd_addr  <= '0;
                exu_wb_rd_wr_en <= 1'b0;
                instr_tag_out   <= '0;
                instr_out       <= '0;
            end
            if (w_conflict && (wb_conflict_cnt != 32'hFFFF_FFFF))
                wb_conflict_cnt <= wb_conflict_cnt + 32'd1;
        end
    end

    a_no_valid_while_full: assert property (
        @(posedge clk) disable iff (!rst_n) ((req_valid & req_ready) == req_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_exu_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exu_wb_arb : scoreboard bench with queue-based reference model     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_exu_wb_arb;
    import exu_wb_arb_pkg::*;

    localparam int NREQ  = 5;
    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    wb_req_t [NREQ-1:0] req_wb = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_pending;
    logic [XLEN-1:0]    exu_wb_data;
    logic [4:0]         exu_wb_rd_addr;
    logic               exu_wb_rd_wr_en;
    logic [XLEN-1:0]    instr_tag_out;
    logic [31:0]        instr_out;
    logic [31:0]        wb_conflict_cnt;

    always #5 clk = ~clk;

    exu_wb_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_wb          (req_wb),
        .req_ready       (req_ready),
        .req_pending     (req_pending),
        .exu_wb_data     (exu_wb_data),
        .exu_wb_rd_addr  (exu_wb_rd_addr),
        .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
        .instr_tag_out   (instr_tag_out),
        .instr_out       (instr_out),
        .wb_conflict_cnt (wb_conflict_cnt)
    );

    typedef struct {
        wb_req_t r;
        int      cyc;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_rr = 0;
    longint     m_conf = 0;
    wb_req_t    mq [NREQ][$];
    exp_t       exp_q [$];
    logic [NREQ-1:0] st_valid;
    wb_req_t    st_wb [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.data      = $urandom;
        r.rd_addr   = 5'($urandom_range(0, 31));
        r.instr_tag = $urandom;
        r.instr     = $urandom | 32'h1;
        return r;
    endfunction

    // One cycle, entered at a negedge: check state, drive inputs, advance model.
    task automatic step();
        logic [NREQ-1:0] m_ready;
        logic [NREQ-1:0] m_pend;
        int n;
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            m_ready[i] = (mq[i].size() < DEPTH);
            m_pend[i]  = (mq[i].size() != 0);
        end
        chk("req_ready", req_ready, m_ready);
        chk("req_pending", req_pending, m_pend);
        chk("conflict_cnt", wb_conflict_cnt, m_conf);
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = st_valid[i] & m_ready[i];
            req_wb[i]    = st_wb[i];
            if (req_valid[i]) mq[i].push_back(st_wb[i]);
        end
        n = 0;
        for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) n++;
        if (n >= 2 && m_conf < 64'hFFFF_FFFF) m_conf++;
        if (n > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int u;
                u = (m_rr + k) % NREQ;
                if (mq[u].size() != 0) begin
                    e.r   = mq[u].pop_front();
                    e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    m_rr  = (u + 1) % NREQ;
                    break;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        st_valid = '0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_wr_en", exu_wb_rd_wr_en, 0);
        chk("rst_data", exu_wb_data, 0);
        chk("rst_tag_instr", {instr_tag_out, instr_out}, 0);
        chk("rst_rd_addr", exu_wb_rd_addr, 0);
        chk("rst_pending", req_pending, 0);
        chk("rst_conflict", wb_conflict_cnt, 0);
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        exp_q.delete();
        m_rr   = 0;
        m_conf = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT retires a result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) continue;
            if (exu_wb_rd_wr_en || instr_out != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got instr %0h expected none (cycle %0d)", instr_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_data", exu_wb_data, e.r.data);
                    chk("wb_rd_addr", exu_wb_rd_addr, e.r.rd_addr);
                    chk("wb_wr_en", exu_wb_rd_wr_en, (e.r.rd_addr != 0));
                    chk("wb_tag", instr_tag_out, e.r.instr_tag);
                    chk("wb_instr", instr_out, e.r.instr);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_wb: got none expected instr %0h (cycle %0d)", e.r.instr, cyc);
            end else begin
                chk("idle_outputs", |{exu_wb_data, exu_wb_rd_addr, instr_tag_out}, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_valid = '0;
        for (int i = 0; i < NREQ; i++) st_wb[i] = '0;
        @(negedge clk);
        do_reset();

        // ALU, MUL, DIV together from rr_ptr 0
        st_valid = '0;
        for (int i = 0; i < NREQ; i++) st_wb[i] = rand_req();
        st_valid[WB_ALU] = 1'b1;
        st_valid[WB_MUL] = 1'b1;
        st_valid[WB_DIV] = 1'b1;
        step();
        idle(4);

        // Single uncontended ALU writeback
        st_valid = '0;
        st_wb[WB_ALU] = '{data: 32'h1234, rd_addr: 5'd5, instr_tag: 32'hA1, instr: 32'h13};
        st_valid[WB_ALU] = 1'b1;
        step();
        idle(3);

        // MUL streams while LSU/ALU/MAC contend: MUL FIFO fills
        for (int c = 0; c < 4; c++) begin
            st_valid = '0;
            for (int i = 0; i < NREQ; i++) st_wb[i] = rand_req();
            st_valid[WB_MUL] = 1'b1;
            st_valid[WB_LSU] = 1'b1;
            st_valid[WB_ALU] = 1'b1;
            st_valid[WB_MAC] = 1'b1;
            step();
        end
        idle(10);

        // MAC result to x0: tag retires, no register write
        st_valid = '0;
        st_wb[WB_MAC] = '{data: 32'hFFFF, rd_addr: 5'd0, instr_tag: 32'hBEEF, instr: 32'h33};
        st_valid[WB_MAC] = 1'b1;
        step();
        idle(3);

        // Reset with two entries buffered
        st_valid = '0;
        for (int i = 0; i < NREQ; i++) st_wb[i] = rand_req();
        st_valid[WB_ALU] = 1'b1;
        st_valid[WB_MUL] = 1'b1;
        st_valid[WB_DIV] = 1'b1;
        step();
        do_reset();
        idle(5);

        // Random traffic with shifting density
        for (int c = 0; c < 10000; c++) begin
            int dens;
            dens = (c / 500) % 4 == 0 ? 15 : (c / 500) % 4 == 1 ? 40 : (c / 500) % 4 == 2 ? 70 : 95;
            for (int i = 0; i < NREQ; i++) begin
                st_valid[i] = ($urandom_range(0, 99) < dens);
                st_wb[i]    = rand_req();
            end
            step();
        end
        idle(20);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
